// File: rtl/srpt_fetch_dma_issue_pkg.sv
// Shared SRPT definitions: queue-entry layout, priority codes and block sizes,
// plus the per-tag record used by the fetch DMA issue stage.
package srpt_fetch_dma_issue_pkg;

  localparam int unsigned CACHE_BLOCK_SIZE = 64;
  localparam int unsigned QUEUE_ENTRY_SIZE = 99;

  localparam int unsigned RPC_ID_W    = 16;
  localparam int unsigned DBUFF_ID_W  = 9;
  localparam int unsigned REMAINING_W = 32;
  localparam int unsigned DBUFFERED_W = 20;
  localparam int unsigned GRANTED_W   = 19;
  localparam int unsigned PRIO_W      = 3;
  localparam int unsigned LEN_W       = 7;

  typedef logic [PRIO_W-1:0] srpt_prio_t;

  localparam srpt_prio_t SRPT_INVALIDATE   = 3'b000;
  localparam srpt_prio_t SRPT_DBUFF_UPDATE = 3'b001;
  localparam srpt_prio_t SRPT_GRANT_UPDATE = 3'b010;
  localparam srpt_prio_t SRPT_EMPTY        = 3'b011;
  localparam srpt_prio_t SRPT_BLOCKED      = 3'b100;
  localparam srpt_prio_t SRPT_ACTIVE       = 3'b101;

  // Queue entry, MSB first: PRIORITY[98:96] GRANTED[95:77] DBUFFERED[76:57]
  // REMAINING[56:25] DBUFF_ID[24:16] RPC_ID[15:0]
  typedef struct packed {
    srpt_prio_t             prio;
    logic [GRANTED_W-1:0]   granted;
    logic [DBUFFERED_W-1:0] dbuffered;
    logic [REMAINING_W-1:0] remaining;
    logic [DBUFF_ID_W-1:0]  dbuff_id;
    logic [RPC_ID_W-1:0]    rpc_id;
  } queue_entry_t;

  typedef struct packed {
    logic [RPC_ID_W-1:0]    rpc_id;
    logic [DBUFF_ID_W-1:0]  dbuff_id;
    logic [DBUFFERED_W-1:0] offset;
    logic [LEN_W-1:0]       len;
  } tag_entry_t;

  typedef enum logic {ST_IDLE, ST_ISSUE} req_state_e;

  // One DMA read covers at most one cache block of the remaining bytes.
  function automatic logic [LEN_W-1:0] dma_chunk_len(input logic [REMAINING_W-1:0] rem);
    return (rem >= REMAINING_W'(CACHE_BLOCK_SIZE)) ? LEN_W'(CACHE_BLOCK_SIZE) : rem[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/srpt_fetch_dma_issue_if.sv
// Handshake bundle of the fetch DMA issue stage: fetch input, DMA read
// request/completion and data-buffer update toward the SRPT data queue.
interface srpt_fetch_dma_issue_if #(
  parameter int unsigned TAG_W = 3
);
  import srpt_fetch_dma_issue_pkg::*;

  logic                   fetch_in_valid_i;
  logic                   fetch_in_ready_o;
  queue_entry_t           fetch_in_data_i;

  logic                   dma_req_valid_o;
  logic                   dma_req_ready_i;
  logic [TAG_W-1:0]       dma_req_tag_o;
  logic [RPC_ID_W-1:0]    dma_req_rpc_id_o;
  logic [DBUFF_ID_W-1:0]  dma_req_dbuff_id_o;
  logic [DBUFFERED_W-1:0] dma_req_offset_o;
  logic [LEN_W-1:0]       dma_req_len_o;

  logic                   dma_cpl_valid_i;
  logic [TAG_W-1:0]       dma_cpl_tag_i;

  logic                   dbuff_upd_valid_o;
  logic                   dbuff_upd_ready_i;
  queue_entry_t           dbuff_upd_data_o;

  modport slave (
    input  fetch_in_valid_i, fetch_in_data_i, dma_req_ready_i,
           dma_cpl_valid_i, dma_cpl_tag_i, dbuff_upd_ready_i,
    output fetch_in_ready_o, dma_req_valid_o, dma_req_tag_o, dma_req_rpc_id_o,
           dma_req_dbuff_id_o, dma_req_offset_o, dma_req_len_o,
           dbuff_upd_valid_o, dbuff_upd_data_o
  );

  modport master (
    output fetch_in_valid_i, fetch_in_data_i, dma_req_ready_i,
           dma_cpl_valid_i, dma_cpl_tag_i, dbuff_upd_ready_i,
    input  fetch_in_ready_o, dma_req_valid_o, dma_req_tag_o, dma_req_rpc_id_o,
           dma_req_dbuff_id_o, dma_req_offset_o, dma_req_len_o,
           dbuff_upd_valid_o, dbuff_upd_data_o
  );

endinterface

// File: rtl/srpt_lsb_select.sv
// Find-lowest-set-bit encoder; found_c_o is low when the vector is empty.
module srpt_lsb_select #(
  parameter int unsigned W     = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             found_c_o
);

  always_comb begin
    idx_c_o   = '0;
    found_c_o = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_c_o   = IDX_W'(i);
        found_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/srpt_fetch_dma_issue.sv
// Issues one-cache-block DMA reads for active fetch-queue entries and returns
// data-buffer updates on completion. Optional counters: SRPT_FETCH_DMA_STATS_EN.
module srpt_fetch_dma_issue
  import srpt_fetch_dma_issue_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TAG_W           = 3
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  srpt_fetch_dma_issue_if.slave bus,
  output logic [TAG_W:0]     outstanding_o,
  output logic               cpl_err_o,
  output logic [31:0]        stat_req_cnt_o,
  output logic [31:0]        stat_cpl_cnt_o
);

  localparam int unsigned CNT_W = TAG_W + 1;

  req_state_e                 state_q, state_d;
  logic                       run_q;
  logic [MAX_OUTSTANDING-1:0] alloc_q, alloc_d, pend_q, pend_d;
  tag_entry_t                 tab_q [MAX_OUTSTANDING];
  logic                       req_valid_q, req_valid_d;
  logic [TAG_W-1:0]           req_tag_q, req_tag_d;
  tag_entry_t                 req_q, req_d;
  logic                       upd_valid_q, upd_valid_d;
  logic [TAG_W-1:0]           upd_tag_q;
  queue_entry_t               upd_data_q, upd_data_d;
  logic [CNT_W-1:0]           out_q, out_d;
  logic                       err_q, err_d;

  logic [TAG_W-1:0] free_tag_c, upd_tag_c;
  logic             free_any_c, upd_any_c;
  logic             ready_c, accept_c, alloc_c, req_hs_c, upd_hs_c, cpl_ok_c;
  logic             unused_granted;

  assign unused_granted = ^bus.fetch_in_data_i.granted;

  srpt_lsb_select #(.W(MAX_OUTSTANDING), .IDX_W(TAG_W)) u_free_sel (
    .vec_i     (~alloc_q),
    .idx_c_o   (free_tag_c),
    .found_c_o (free_any_c)
  );

  srpt_lsb_select #(.W(MAX_OUTSTANDING), .IDX_W(TAG_W)) u_pend_sel (
    .vec_i     (pend_d),
    .idx_c_o   (upd_tag_c),
    .found_c_o (upd_any_c)
  );

  // Free tags come from the registered map, so a tag freed this cycle waits one cycle.
  assign ready_c  = run_q & free_any_c & ((state_q == ST_IDLE) | bus.dma_req_ready_i);
  assign accept_c = bus.fetch_in_valid_i & ready_c;
  assign alloc_c  = accept_c & (bus.fetch_in_data_i.prio == SRPT_ACTIVE)
                  & (bus.fetch_in_data_i.remaining != '0);
  assign req_hs_c = req_valid_q & bus.dma_req_ready_i;
  assign upd_hs_c = upd_valid_q & bus.dbuff_upd_ready_i;
  assign cpl_ok_c = alloc_q[bus.dma_cpl_tag_i] & ~pend_q[bus.dma_cpl_tag_i];

  // Request FSM: next state and held request payload.
  always_comb begin
    state_d   = state_q;
    req_tag_d = req_tag_q;
    req_d     = req_q;
    unique case (state_q)
      ST_IDLE:  if (alloc_c) state_d = ST_ISSUE;
      ST_ISSUE: if (bus.dma_req_ready_i) state_d = alloc_c ? ST_ISSUE : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (alloc_c) begin
      req_tag_d      = free_tag_c;
      req_d.rpc_id   = bus.fetch_in_data_i.rpc_id;
      req_d.dbuff_id = bus.fetch_in_data_i.dbuff_id;
      req_d.offset   = bus.fetch_in_data_i.dbuffered;
      req_d.len      = dma_chunk_len(bus.fetch_in_data_i.remaining);
    end
    req_valid_d = (state_d == ST_ISSUE);
  end

  // Tag bookkeeping: free, completion and allocation all land on the same edge.
  always_comb begin
    alloc_d = alloc_q;
    pend_d  = pend_q;
    err_d   = err_q;
    out_d   = '0;
    if (upd_hs_c) begin
      alloc_d[upd_tag_q] = 1'b0;
      pend_d[upd_tag_q]  = 1'b0;
    end
    if (bus.dma_cpl_valid_i) begin
      if (cpl_ok_c) pend_d[bus.dma_cpl_tag_i] = 1'b1;
      else          err_d = 1'b1;
    end
    if (alloc_c) alloc_d[free_tag_c] = 1'b1;
    for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
      out_d = out_d + CNT_W'(alloc_d[i]);
    end
  end

  // Update payload always tracks the lowest pending tag.
  always_comb begin
    upd_valid_d = upd_any_c;
    upd_data_d  = '0;
    if (upd_any_c) begin
      upd_data_d.rpc_id    = tab_q[upd_tag_c].rpc_id;
      upd_data_d.dbuff_id  = tab_q[upd_tag_c].dbuff_id;
      upd_data_d.dbuffered = tab_q[upd_tag_c].offset + DBUFFERED_W'(tab_q[upd_tag_c].len);
      upd_data_d.prio      = SRPT_DBUFF_UPDATE;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      alloc_q     <= '0;
      pend_q      <= '0;
      req_valid_q <= 1'b0;
      req_tag_q   <= '0;
      req_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_tag_q   <= '0;
      upd_data_q  <= '0;
      out_q       <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) tab_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      alloc_q     <= alloc_d;
      pend_q      <= pend_d;
      req_valid_q <= req_valid_d;
      req_tag_q   <= req_tag_d;
      req_q       <= req_d;
      upd_valid_q <= upd_valid_d;
      upd_tag_q   <= upd_tag_c;
      upd_data_q  <= upd_data_d;
      out_q       <= out_d;
      err_q       <= err_d;
      if (alloc_c) tab_q[free_tag_c] <= req_d;
    end
  end

`ifdef SRPT_FETCH_DMA_STATS_EN
  logic [31:0] stat_req_q, stat_cpl_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_req_q <= '0;
      stat_cpl_q <= '0;
    end else begin
      if (req_hs_c) stat_req_q <= stat_req_q + 32'd1;
      if (upd_hs_c) stat_cpl_q <= stat_cpl_q + 32'd1;
    end
  end

  assign stat_req_cnt_o = stat_req_q;
  assign stat_cpl_cnt_o = stat_cpl_q;
`else
  logic unused_req_hs;
  assign unused_req_hs  = req_hs_c;
  assign stat_req_cnt_o = '0;
  assign stat_cpl_cnt_o = '0;
`endif

  assign bus.fetch_in_ready_o   = ready_c;
  assign bus.dma_req_valid_o    = req_valid_q;
  assign bus.dma_req_tag_o      = req_tag_q;
  assign bus.dma_req_rpc_id_o   = req_q.rpc_id;
  assign bus.dma_req_dbuff_id_o = req_q.dbuff_id;
  assign bus.dma_req_offset_o   = req_q.offset;
  assign bus.dma_req_len_o      = req_q.len;
  assign bus.dbuff_upd_valid_o  = upd_valid_q;
  assign bus.dbuff_upd_data_o   = upd_data_q;
  assign outstanding_o          = out_q;
  assign cpl_err_o              = err_q;

endmodule

// File: doc/srpt_fetch_dma_issue.md
SRPT_FETCH_DMA_ISSUE -- requirements
Module: srpt_fetch_dma_issue

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, power of two; number of in-flight DMA read tags.
REQ-002 SHALL have parameter TAG_W, default 3, equal to log2(MAX_OUTSTANDING).
REQ-003 ap_clk  input  1  sole clock; all state on rising edge.
REQ-004 ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_in_valid_i  input  1  fetch-queue head entry valid.
REQ-006 fetch_in_ready_o  output  1  entry accepted this cycle when high with valid.
REQ-007 fetch_in_data_i  input  99  queue entry, standard field layout (RPC_ID, DBUFF_ID, REMAINING, DBUFFERED, GRANTED, PRIORITY).
REQ-008 dma_req_valid_o / dma_req_ready_i  output/input  1/1  DMA read request handshake.
REQ-009 dma_req_tag_o  output  TAG_W  tag of request.
REQ-010 dma_req_rpc_id_o  output  16;  dma_req_dbuff_id_o  output  9;  dma_req_offset_o  output  20;  dma_req_len_o  output  7.
REQ-011 dma_cpl_valid_i  input  1;  dma_cpl_tag_i  input  TAG_W  read completion, always accepted, no backpressure.
REQ-012 dbuff_upd_valid_o / dbuff_upd_ready_i  output/input  1/1;  dbuff_upd_data_o  output  99  cache-update entry toward the SRPT data queue.
REQ-013 outstanding_o  output  TAG_W+1  count of allocated tags.
REQ-014 cpl_err_o  output  1  sticky: completion received for an unallocated tag.
REQ-015 stat_req_cnt_o, stat_cpl_cnt_o  output  32/32  statistics counters (see Configuration).

Function
REQ-016 Request stage SHALL be a two-state FSM: IDLE (dma_req_valid_o=0), ISSUE (dma_req_valid_o=1, all dma_req_* stable until dma_req_ready_i).
REQ-017 fetch_in_ready_o SHALL be 1 iff FSM is IDLE, or ISSUE with dma_req_ready_i=1, AND at least one tag is free.
REQ-018 An accepted entry with PRIORITY != SRPT_ACTIVE (3'b101) or REMAINING == 0 SHALL be consumed and dropped; no tag, no request.
REQ-019 An accepted active entry SHALL allocate the lowest-numbered free tag and enter ISSUE on the next cycle (latency 1).
REQ-020 Request fields: offset = DBUFFERED; len = 64 if REMAINING >= 64, else REMAINING[6:0]; rpc_id/dbuff_id copied.
REQ-021 Tag table SHALL store {rpc_id, dbuff_id, offset, len} per tag until the tag is freed.
REQ-022 dma_cpl_valid_i on an allocated, non-pending tag SHALL set that tag's pending bit; on any other tag it SHALL be ignored and set cpl_err_o.
REQ-023 dbuff_upd_valid_o SHALL be high while any pending bit is set, presenting the lowest pending tag, registered (completion in cycle N visible no earlier than N+1).
REQ-024 dbuff_upd_data_o: RPC_ID, DBUFF_ID from table; DBUFFERED = offset+len (20-bit, wraps modulo 2^20); PRIORITY = SRPT_DBUFF_UPDATE (3'b001); all other bits 0.
REQ-025 Tag SHALL be freed (allocated and pending cleared) on the dbuff_upd handshake; a tag freed in cycle N SHALL NOT be reallocated before N+1.
REQ-026 Allocation and completion or free in the same cycle SHALL all take effect; outstanding_o = allocated count after the edge.
REQ-027 With all tags allocated, fetch_in_ready_o SHALL be 0; the FSM may still complete an ISSUE in progress.
REQ-028 dbuff_upd_data_o SHALL hold stable while valid and not ready, unless a lower tag becomes pending (re-selection permitted only between handshakes is NOT required; lowest-pending rule wins).

Reset
REQ-029 Asserting ap_rst_n low SHALL immediately clear FSM to IDLE, all allocated/pending bits, cpl_err_o, counters; all outputs 0.
REQ-030 Reset mid-ISSUE SHALL drop the request; completions for pre-reset tags after reset SHALL set cpl_err_o.

Configuration
REQ-031 Macro SRPT_FETCH_DMA_STATS_EN defined: stat_req_cnt_o increments per DMA request handshake, stat_cpl_cnt_o per dbuff_upd handshake, both wrap at 2^32.
REQ-032 Macro undefined: counters not built; stat_* ports tied to 0.

Structure
REQ-033 Queue-entry field ranges, SRPT priority codes, CACHE_BLOCK_SIZE (64) and QUEUE_ENTRY_SIZE (99) SHALL live in the shared SRPT definitions header, not redefined locally.
REQ-034 One sub-module, srpt_lsb_select (parameterised find-lowest-set-bit encoder), SHALL be instantiated twice: free-tag allocation and pending-completion selection.

Verification
REQ-035 Active entry REMAINING=512, DBUFFERED=0, rpc 7 -> one request tag 0, offset 0, len 64, next cycle after accept.
REQ-036 Active entry REMAINING=40, DBUFFERED=448 -> len 40; completion tag 0 -> update DBUFFERED=488, PRIORITY=1, outstanding back to 0.
REQ-037 Nine back-to-back entries, no completions -> tags 0..7 issued, ninth held (ready=0) until one update handshake, then issued with freed tag.
REQ-038 Completions tags 5 then 2 with dbuff_upd_ready_i=0 -> update shows tag 2 first once ready asserts, then tag 5.
REQ-039 Entry PRIORITY=SRPT_EMPTY, and completion on unallocated tag 3 -> entry dropped, no request; cpl_err_o=1.
REQ-040 ap_rst_n low during ISSUE -> all outputs 0 same cycle; with SRPT_FETCH_DMA_STATS_EN, counters read 0 after reset.
